// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry layout and small helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int NUM_ROB_ENTS = 64;
  localparam int DISP_WIDTH   = 2;
  localparam int RETIRE_WIDTH = 4;
  localparam int NUM_FUS      = 4;
  localparam int DST_REG_W    = 6;
  localparam int PC_W         = 32;

  localparam int ROB_IDX_W    = $clog2(NUM_ROB_ENTS);
  localparam int ROB_PTR_W    = ROB_IDX_W + 1;

  // Highest occupancy that still leaves room for a full dispatch group.
  localparam logic [ROB_PTR_W-1:0] DISP_LIMIT = ROB_PTR_W'(NUM_ROB_ENTS - DISP_WIDTH);

  typedef struct packed {
    logic [DST_REG_W-1:0] dst_reg;
    logic                 exception;
    logic                 br_mispred;
    logic [PC_W-1:0]      pc;
  } rob_entry_t;

  typedef struct packed {
    rob_entry_t entry;
    logic       valid;
    logic       done;
  } rob_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 exception;
    logic                 br_mispred;
  } cmpl_port_t;

  // Number of set bits in an 8-bit vector (narrower lane vectors are zero-extended).
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // An entry that must end its retire group and trigger a flush.
  function automatic logic is_flagged(input rob_entry_t e);
    return e.exception | e.br_mispred;
  endfunction

endpackage

// File: rtl/reorder_buffer_chk.sv
// Protocol and consistency assertions for the reorder buffer.
module reorder_buffer_chk
  import reorder_buffer_pkg::*;
(
  input logic                               clk,
  input logic                               rst_n,
  input logic                               flush_i,
  input logic [DISP_WIDTH-1:0]              disp_valid_i,
  input logic [NUM_FUS-1:0]                 cmpl_valid_i,
  input logic [NUM_FUS-1:0][ROB_IDX_W-1:0]  cmpl_rob_idx_i,
  input logic [NUM_ROB_ENTS-1:0]            slot_valid_i,
  input logic [ROB_PTR_W-1:0]               head_i,
  input logic [ROB_PTR_W-1:0]               tail_i,
  input logic [ROB_PTR_W-1:0]               count_i
);

  localparam logic [DISP_WIDTH-1:0] LANE_ONE = DISP_WIDTH'(1);

  logic full_s;
  logic empty_s;

  assign full_s  = (head_i[ROB_IDX_W-1:0] == tail_i[ROB_IDX_W-1:0]) &&
                   (head_i[ROB_IDX_W] != tail_i[ROB_IDX_W]);
  assign empty_s = (head_i == tail_i);

  // Dispatch lanes must be a contiguous run starting at lane 0.
  a_disp_contig: assert property (@(posedge clk) disable iff (!rst_n)
    ((disp_valid_i & (disp_valid_i + LANE_ONE)) == '0));

  // Occupancy counter agrees with the pointer distance and the full/empty encoding.
  a_count_ptr: assert property (@(posedge clk) disable iff (!rst_n)
    (count_i == ROB_PTR_W'(tail_i - head_i)));
  a_full: assert property (@(posedge clk) disable iff (!rst_n)
    (full_s == (count_i == ROB_PTR_W'(NUM_ROB_ENTS))));
  a_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (empty_s == (count_i == '0)));

  // Completions must target an allocated entry (ignored during the flush cycle).
  for (genvar f = 0; f < NUM_FUS; f++) begin : g_cmpl_chk
    a_cmpl_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (cmpl_valid_i[f] && !flush_i) |-> slot_valid_i[cmpl_rob_idx_i[f]]);
  end

endmodule

// File: rtl/rob_retire_sel.sv
// Picks the in-order retire group from the RETIRE_WIDTH slots starting at head.
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  rob_slot_t  [RETIRE_WIDTH-1:0] slots_i,
  output logic       [RETIRE_WIDTH-1:0] ret_valid_o,
  output rob_entry_t [RETIRE_WIDTH-1:0] ret_entry_o,
  output logic                          flush_req_o,
  output logic       [PC_W-1:0]         flush_pc_o
);

  // Walk lanes in order; a lane retires while the chain is unbroken, and a flagged lane closes it.
  always_comb begin
    logic chain;
    chain       = 1'b1;
    ret_valid_o = '0;
    flush_req_o = 1'b0;
    flush_pc_o  = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      ret_entry_o[i] = slots_i[i].entry;
      if (chain && slots_i[i].valid && slots_i[i].done) begin
        ret_valid_o[i] = 1'b1;
        if (is_flagged(slots_i[i].entry)) begin
          flush_req_o = 1'b1;
          flush_pc_o  = slots_i[i].entry.pc;
          chain       = 1'b0;
        end else begin
          chain = 1'b1;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane dispatch, multi-port completion,
// in-order multi-lane retire, and a one-cycle flush after a flagged entry retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic       [DISP_WIDTH-1:0]        disp_valid_i,
  input  rob_entry_t [DISP_WIDTH-1:0]        disp_entry_i,
  output logic                               disp_ready_o,
  output logic [DISP_WIDTH-1:0][ROB_IDX_W-1:0] disp_rob_idx_o,
  input  logic       [NUM_FUS-1:0]           cmpl_valid_i,
  input  logic [NUM_FUS-1:0][ROB_IDX_W-1:0]  cmpl_rob_idx_i,
  input  logic       [NUM_FUS-1:0]           cmpl_exception_i,
  input  logic       [NUM_FUS-1:0]           cmpl_br_mispred_i,
  output logic       [RETIRE_WIDTH-1:0]      ret_valid_o,
  output rob_entry_t [RETIRE_WIDTH-1:0]      ret_entry_o,
  output logic                               flush_o,
  output logic       [PC_W-1:0]              flush_pc_o,
  output logic       [ROB_PTR_W-1:0]         rob_count_o
);

  rob_slot_t slots_q [NUM_ROB_ENTS];
  rob_slot_t slots_d [NUM_ROB_ENTS];

  logic [ROB_PTR_W-1:0] head_q, head_d;
  logic [ROB_PTR_W-1:0] tail_q, tail_d;
  logic [ROB_PTR_W-1:0] count_q, count_d;
  logic                 flush_q, flush_d;
  logic [PC_W-1:0]      flush_pc_q, flush_pc_d;

  rob_slot_t  [RETIRE_WIDTH-1:0] win_s;
  cmpl_port_t [NUM_FUS-1:0]      cmpl_s;
  logic                          flush_req_s;
  logic [PC_W-1:0]               ret_flush_pc_s;
  logic [3:0]                    n_alloc_s;
  logic [3:0]                    n_ret_s;
  logic [NUM_ROB_ENTS-1:0]       slot_valid_s;

  // Free-space check uses the registered count only; nothing is accepted during a flush.
  assign disp_ready_o = !flush_q && (count_q <= DISP_LIMIT);
  assign flush_o      = flush_q;
  assign flush_pc_o   = flush_pc_q;
  assign rob_count_o  = count_q;

  assign n_alloc_s = disp_ready_o ? popcnt8(8'(disp_valid_i)) : 4'd0;
  assign n_ret_s   = popcnt8(8'(ret_valid_o));

  // Gather the retire window at head and the allocation indices at tail, wrapping at the end.
  always_comb begin
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      win_s[i] = slots_q[ROB_IDX_W'(head_q + ROB_PTR_W'(i))];
    end
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_rob_idx_o[i] = ROB_IDX_W'(tail_q + ROB_PTR_W'(i));
    end
  end

  // Bundle the per-FU completion fields.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      cmpl_s[f].valid      = cmpl_valid_i[f];
      cmpl_s[f].rob_idx    = cmpl_rob_idx_i[f];
      cmpl_s[f].exception  = cmpl_exception_i[f];
      cmpl_s[f].br_mispred = cmpl_br_mispred_i[f];
    end
  end

  rob_retire_sel u_retire_sel (
    .slots_i     (win_s),
    .ret_valid_o (ret_valid_o),
    .ret_entry_o (ret_entry_o),
    .flush_req_o (flush_req_s),
    .flush_pc_o  (ret_flush_pc_s)
  );

  // Next-state: flush cycle holds, a flagged retire empties the buffer, otherwise complete/retire/dispatch.
  always_comb begin
    slots_d    = slots_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;

    if (flush_q) begin
      // Buffer is already empty; dispatch and completions this cycle are dropped.
      flush_d = 1'b0;
    end else if (flush_req_s) begin
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        slots_d[e].valid = 1'b0;
        slots_d[e].done  = 1'b0;
      end
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = ret_flush_pc_s;
    end else begin
      // Completion: only allocated entries accept it; flags from several ports accumulate.
      for (int f = 0; f < NUM_FUS; f++) begin
        if (cmpl_s[f].valid && slots_q[cmpl_s[f].rob_idx].valid) begin
          slots_d[cmpl_s[f].rob_idx].done = 1'b1;
          slots_d[cmpl_s[f].rob_idx].entry.exception =
            slots_d[cmpl_s[f].rob_idx].entry.exception | cmpl_s[f].exception;
          slots_d[cmpl_s[f].rob_idx].entry.br_mispred =
            slots_d[cmpl_s[f].rob_idx].entry.br_mispred | cmpl_s[f].br_mispred;
        end else begin
          slots_d[cmpl_s[f].rob_idx].done = slots_d[cmpl_s[f].rob_idx].done;
        end
      end
      // Retire: free the slots that leave at this edge.
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (ret_valid_o[i]) begin
          slots_d[ROB_IDX_W'(head_q + ROB_PTR_W'(i))].valid = 1'b0;
          slots_d[ROB_IDX_W'(head_q + ROB_PTR_W'(i))].done  = 1'b0;
        end else begin
          head_d = head_d;
        end
      end
      // Dispatch: allocated slots were free, so they never collide with completion or retire.
      for (int i = 0; i < DISP_WIDTH; i++) begin
        if (disp_ready_o && disp_valid_i[i]) begin
          slots_d[ROB_IDX_W'(tail_q + ROB_PTR_W'(i))] =
            '{entry: disp_entry_i[i], valid: 1'b1, done: 1'b0};
        end else begin
          tail_d = tail_d;
        end
      end
      head_d  = head_q + ROB_PTR_W'(n_ret_s);
      tail_d  = tail_q + ROB_PTR_W'(n_alloc_s);
      count_d = count_q + ROB_PTR_W'(n_alloc_s) - ROB_PTR_W'(n_ret_s);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        slots_q[e] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        slots_q[e] <= slots_d[e];
      end
    end
  end

  // Flatten the per-slot valid bits for the checker.
  always_comb begin
    for (int e = 0; e < NUM_ROB_ENTS; e++) begin
      slot_valid_s[e] = slots_q[e].valid;
    end
  end

  reorder_buffer_chk u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_q),
    .disp_valid_i   (disp_valid_i),
    .cmpl_valid_i   (cmpl_valid_i),
    .cmpl_rob_idx_i (cmpl_rob_idx_i),
    .slot_valid_i   (slot_valid_s),
    .head_i         (head_q),
    .tail_i         (tail_q),
    .count_i        (count_q)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a program-order queue model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                                 clk = 1'b0;
  logic                                 rst_n;
  logic       [DISP_WIDTH-1:0]          disp_valid;
  rob_entry_t [DISP_WIDTH-1:0]          disp_entry;
  logic                                 disp_ready;
  logic [DISP_WIDTH-1:0][ROB_IDX_W-1:0] disp_rob_idx;
  logic       [NUM_FUS-1:0]             cmpl_valid;
  logic [NUM_FUS-1:0][ROB_IDX_W-1:0]    cmpl_idx;
  logic       [NUM_FUS-1:0]             cmpl_exc;
  logic       [NUM_FUS-1:0]             cmpl_mis;
  logic       [RETIRE_WIDTH-1:0]        ret_valid;
  rob_entry_t [RETIRE_WIDTH-1:0]        ret_entry;
  logic                                 flush;
  logic [31:0]                          flush_pc;
  logic [ROB_PTR_W-1:0]                 rob_count;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .disp_valid_i      (disp_valid),
    .disp_entry_i      (disp_entry),
    .disp_ready_o      (disp_ready),
    .disp_rob_idx_o    (disp_rob_idx),
    .cmpl_valid_i      (cmpl_valid),
    .cmpl_rob_idx_i    (cmpl_idx),
    .cmpl_exception_i  (cmpl_exc),
    .cmpl_br_mispred_i (cmpl_mis),
    .ret_valid_o       (ret_valid),
    .ret_entry_o       (ret_entry),
    .flush_o           (flush),
    .flush_pc_o        (flush_pc),
    .rob_count_o       (rob_count)
  );

  // Model: occupied entries in program order; the oldest sits at index m_head.
  typedef struct { rob_entry_t e; bit done; } mrec_t;
  mrec_t       mq[$];
  int          m_head = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_flush_pc = 32'h0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // How many oldest entries retire now, and whether the last one is flagged.
  function automatic void model_ret(output int n, output bit flag);
    n = 0;
    flag = 1'b0;
    while (n < RETIRE_WIDTH && n < mq.size()) begin
      if (!mq[n].done) break;
      n++;
      if (mq[n-1].e.exception || mq[n-1].e.br_mispred) begin
        flag = 1'b1;
        break;
      end
    end
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int  n;
    bit  flag;
    bit  ready;
    int  off;
    mrec_t r;
    if (!rst_n) begin
      mq.delete();
      m_head = 0;
      m_flush = 1'b0;
      m_flush_pc = 32'h0;
      return;
    end
    if (m_flush) begin
      m_flush = 1'b0;
      return;
    end
    model_ret(n, flag);
    ready = (NUM_ROB_ENTS - mq.size()) >= DISP_WIDTH;
    if (flag) begin
      m_flush_pc = mq[n-1].e.pc;
      mq.delete();
      m_head = 0;
      m_flush = 1'b1;
      return;
    end
    for (int f = 0; f < NUM_FUS; f++) begin
      if (cmpl_valid[f]) begin
        off = (int'(cmpl_idx[f]) - m_head + NUM_ROB_ENTS) % NUM_ROB_ENTS;
        if (off < mq.size()) begin
          mq[off].done = 1'b1;
          mq[off].e.exception  = mq[off].e.exception  | cmpl_exc[f];
          mq[off].e.br_mispred = mq[off].e.br_mispred | cmpl_mis[f];
        end
      end
    end
    for (int k = 0; k < n; k++) void'(mq.pop_front());
    m_head = (m_head + n) % NUM_ROB_ENTS;
    if (ready) begin
      for (int l = 0; l < DISP_WIDTH; l++) begin
        if (disp_valid[l]) begin
          r.e = disp_entry[l];
          r.done = 1'b0;
          mq.push_back(r);
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int   n;
      bit   fl;
      logic [RETIRE_WIDTH-1:0] rv;
      model_ret(n, fl);
      rv = RETIRE_WIDTH'((1 << n) - 1);
      if (m_flush) rv = '0;
      chk("rob_count", 64'(rob_count), 64'(mq.size()));
      chk("disp_ready", 64'(disp_ready),
          64'(!m_flush && ((NUM_ROB_ENTS - mq.size()) >= DISP_WIDTH)));
      chk("flush", 64'(flush), 64'(m_flush));
      if (m_flush) chk("flush_pc", 64'(flush_pc), 64'(m_flush_pc));
      chk("ret_valid", 64'(ret_valid), 64'(rv));
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (rv[i]) chk("ret_entry", 64'(ret_entry[i]), 64'(mq[i].e));
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
        chk("disp_rob_idx", 64'(disp_rob_idx[i]),
            64'((m_head + mq.size() + i) % NUM_ROB_ENTS));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    disp_valid = '0;
    disp_entry = '0;
    cmpl_valid = '0;
    cmpl_idx   = '0;
    cmpl_exc   = '0;
    cmpl_mis   = '0;
  endtask

  function automatic rob_entry_t mk(input logic [31:0] pc);
    rob_entry_t e;
    e.dst_reg    = pc[7:2];
    e.exception  = 1'b0;
    e.br_mispred = 1'b0;
    e.pc         = pc;
    return e;
  endfunction

  task automatic dispatch2(input logic [31:0] pc0);
    disp_valid    = 2'b11;
    disp_entry[0] = mk(pc0);
    disp_entry[1] = mk(pc0 + 32'd4);
    tick();
    clear_in();
  endtask

  task automatic complete_range(input int first, input int cnt);
    for (int b = 0; b < cnt; b += NUM_FUS) begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (b + f < cnt) begin
          cmpl_valid[f] = 1'b1;
          cmpl_idx[f]   = ROB_IDX_W'((first + b + f) % NUM_ROB_ENTS);
        end
      end
      tick();
      clear_in();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    do_reset();
    chk_en = 1'b1;

    // Reset state and basic dispatch/complete/retire.
    chk("rst_count", 64'(rob_count), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    chk("t1_idx0", 64'(disp_rob_idx[0]), 64'd0);
    chk("t1_idx1", 64'(disp_rob_idx[1]), 64'd1);
    dispatch2(32'h100);
    chk("t1_count2", 64'(rob_count), 64'd2);
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd1; tick(); clear_in();
    chk("t1_no_ret", 64'(ret_valid), 64'd0);
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd0; tick(); clear_in();
    chk("t1_ret_valid", 64'(ret_valid), 64'h3);
    chk("t1_ret_pc0", 64'(ret_entry[0].pc), 64'h100);
    chk("t1_ret_pc1", 64'(ret_entry[1].pc), 64'h104);
    tick();
    chk("t1_count0", 64'(rob_count), 64'd0);

    // Fill to full, then retire four.
    do_reset();
    for (int k = 0; k < 32; k++) dispatch2(32'h1000 + 32'(k * 8));
    chk("t2_full_count", 64'(rob_count), 64'd64);
    chk("t2_full_ready", 64'(disp_ready), 64'd0);
    complete_range(0, 4);
    chk("t2_ret4", 64'(ret_valid), 64'hf);
    chk("t2_still_full", 64'(disp_ready), 64'd0);
    tick();
    chk("t2_ready_again", 64'(disp_ready), 64'd1);
    chk("t2_count60", 64'(rob_count), 64'd60);
    complete_range(4, 60);
    tick(); tick();
    chk("t2_drained", 64'(rob_count), 64'd0);

    // Wrap-around at index 63 -> 0.
    do_reset();
    for (int k = 0; k < 31; k++) dispatch2(32'h2000 + 32'(k * 8));
    complete_range(0, 62);
    tick(); tick();
    chk("t3_idx62", 64'(disp_rob_idx[0]), 64'd62);
    chk("t3_idx63", 64'(disp_rob_idx[1]), 64'd63);
    dispatch2(32'h3000);
    chk("t3_idx0", 64'(disp_rob_idx[0]), 64'd0);
    chk("t3_idx1", 64'(disp_rob_idx[1]), 64'd1);
    dispatch2(32'h3008);
    cmpl_valid = 4'hf;
    cmpl_idx[0] = 6'd62; cmpl_idx[1] = 6'd63; cmpl_idx[2] = 6'd0; cmpl_idx[3] = 6'd1;
    tick(); clear_in();
    chk("t3_ret4", 64'(ret_valid), 64'hf);
    chk("t3_pc0", 64'(ret_entry[0].pc), 64'h3000);
    chk("t3_pc2", 64'(ret_entry[2].pc), 64'h3008);
    chk("t3_pc3", 64'(ret_entry[3].pc), 64'h300c);
    tick();
    chk("t3_count0", 64'(rob_count), 64'd0);
    chk("t3_tail2", 64'(disp_rob_idx[0]), 64'd2);

    // Mispredict on idx1: retire 0,1 then flush.
    do_reset();
    dispatch2(32'h200);
    dispatch2(32'h208);
    cmpl_valid = 4'hf;
    cmpl_idx[0] = 6'd0; cmpl_idx[1] = 6'd1; cmpl_idx[2] = 6'd2; cmpl_idx[3] = 6'd3;
    cmpl_mis[1] = 1'b1;
    tick(); clear_in();
    chk("t4_ret2", 64'(ret_valid), 64'h3);
    chk("t4_lane1_mis", 64'(ret_entry[1].br_mispred), 64'd1);
    tick();
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_flush_pc", 64'(flush_pc), 64'h204);
    chk("t4_count0", 64'(rob_count), 64'd0);
    chk("t4_ready0", 64'(disp_ready), 64'd0);
    chk("t4_no_ret", 64'(ret_valid), 64'd0);
    disp_valid = 2'b11; disp_entry[0] = mk(32'h900); disp_entry[1] = mk(32'h904);
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd0;
    tick(); clear_in();
    chk("t4_flush_done", 64'(flush), 64'd0);
    chk("t4_drop_disp", 64'(rob_count), 64'd0);
    chk("t4_ready1", 64'(disp_ready), 64'd1);

    // Four FUs hit 5,6,7,7 with an exception on FU3.
    do_reset();
    for (int k = 0; k < 5; k++) dispatch2(32'h500 + 32'(k * 8));
    complete_range(0, 4);
    cmpl_valid = 4'hf;
    cmpl_idx[0] = 6'd5; cmpl_idx[1] = 6'd6; cmpl_idx[2] = 6'd7; cmpl_idx[3] = 6'd7;
    cmpl_exc[3] = 1'b1;
    tick(); clear_in();
    cmpl_valid = 4'h7;
    cmpl_idx[0] = 6'd4; cmpl_idx[1] = 6'd8; cmpl_idx[2] = 6'd9;
    tick(); clear_in();
    chk("t5_ret4", 64'(ret_valid), 64'hf);
    chk("t5_lane3_exc", 64'(ret_entry[3].exception), 64'd1);
    chk("t5_lane3_pc", 64'(ret_entry[3].pc), 64'h51c);
    tick();
    chk("t5_flush", 64'(flush), 64'd1);
    chk("t5_flush_pc", 64'(flush_pc), 64'h51c);
    chk("t5_count0", 64'(rob_count), 64'd0);
    tick();

    // Reset with 20 entries and a flagged head.
    do_reset();
    for (int k = 0; k < 10; k++) dispatch2(32'h700 + 32'(k * 8));
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd0; cmpl_exc[0] = 1'b1;
    tick(); clear_in();
    chk("t6_count20", 64'(rob_count), 64'd20);
    chk("t6_head_ret", 64'(ret_valid), 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_count0", 64'(rob_count), 64'd0);
    chk("t6_ret0", 64'(ret_valid), 64'd0);
    chk("t6_flush0", 64'(flush), 64'd0);
    chk("t6_ready1", 64'(disp_ready), 64'd1);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised circular reorder buffer for the out-of-order core. It allocates up to DISP_WIDTH entries per cycle at dispatch and marks entries done from NUM_FUS completion ports. It retires up to RETIRE_WIDTH entries in program order. On the oldest excepting or mispredicted entry it retires that entry, then raises a one-cycle flush that empties the buffer.

Parameters:
NUM_ROB_ENTS, 64, entry count; power of two, at least 4
DISP_WIDTH, 2, dispatch lanes per cycle
RETIRE_WIDTH, 4, retire lanes per cycle
NUM_FUS, 4, completion ports
ROB_IDX_W, $clog2(NUM_ROB_ENTS), derived entry index width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
disp_valid  in  DISP_WIDTH  per-lane dispatch request; lanes must be contiguous from lane 0
disp_entry  in  DISP_WIDTH x ROB_Entry  dst_reg, exception, br_mispred, pc per lane
disp_ready  out  1  free entries >= DISP_WIDTH (registered count only)
disp_rob_idx  out  DISP_WIDTH x ROB_IDX_W  index allocated to lane i, equal to (tail+i) mod NUM_ROB_ENTS
cmpl_valid  in  NUM_FUS  completion strobe per FU
cmpl_rob_idx  in  NUM_FUS x ROB_IDX_W  completing entry
cmpl_exception  in  NUM_FUS  exception flag from FU
cmpl_br_mispred  in  NUM_FUS  mispredict flag from FU
ret_valid  out  RETIRE_WIDTH  retiring lanes; contiguous from lane 0
ret_entry  out  RETIRE_WIDTH x ROB_Entry  retiring entry contents; flags are final, including completion ORs
flush  out  1  one-cycle pulse after a flagged entry retires
flush_pc  out  32  pc of that flagged entry, valid while flush=1
rob_count  out  ROB_IDX_W+1  occupied entries

Behaviour:
- Storage:
  - Per entry: ROB_Entry, valid, done.
  - head and tail are ROB_IDX_W+1 bits, with the MSB as the wrap bit.
  - full: indices equal, wrap bits differ. empty: pointers equal.
- Reset (rst_n=0 at posedge):
  - head=tail=0; all valid/done cleared; rob_count=0.
  - flush=0; flush_pc=0.
  - Next cycle: ret_valid=0; disp_ready=1.
- Dispatch:
  - Accepted at the edge when disp_ready=1. Writes popcount(disp_valid) entries with valid=1 and done=0, stored flags taken from disp_entry.
  - tail advances by the popcount, modulo 2*NUM_ROB_ENTS.
  - disp_valid with disp_ready=0 is dropped; the upstream holds it.
  - Non-contiguous disp_valid is a protocol error: simulation assertion, no defined result.
- Completion:
  - At the edge, for each cmpl_valid: done=1; exception and br_mispred are ORed into the entry.
  - Several ports hitting the same index: flags are ORed.
  - Completion to an invalid entry is ignored, with an assertion.
  - Earliest completion is the cycle after dispatch.
- Retire (combinational from registered state, via rob_retire_sel):
  - ret_valid[i]=1 iff entries head..head+i are all valid and done, and none of head..head+i-1 is flagged.
  - A flagged entry is therefore the last lane of its group.
  - head advances by popcount(ret_valid) at the edge.
  - An entry done at edge t is retireable in cycle t+1 at the earliest.
- Flush:
  - If a flagged entry retires at edge t, then during cycle t+1: flush=1 and flush_pc=that entry's pc.
  - At edge t, all valid bits clear, head=tail=0, rob_count=0.
  - During the flush cycle, disp_ready=0; dispatch and completion are ignored.
- Simultaneous dispatch and retire: rob_count' = rob_count + allocated − retired. Retire-freed entries are not bypassed to disp_ready.
- Wrap-around: index = pointer[ROB_IDX_W-1:0]; allocation and retire groups may straddle index NUM_ROB_ENTS-1 to 0.
- rob_count reaches NUM_ROB_ENTS when full, so it is ROB_IDX_W+1 bits.

Decomposition:
- Shared package additions:
  - ROB_IDX_W and ROB_PTR_W localparams.
  - Rob_Slot packed struct: ROB_Entry entry, logic valid, logic done.
  - Completion-port struct: valid, rob_idx, exception, br_mispred.
- Existing ROB_Entry and sizing parameters stay in the package.
- One sub-module, rob_retire_sel: purely combinational. Inputs are RETIRE_WIDTH slots starting at head; outputs are ret_valid and a flush-request indicator for the retiring flagged entry.

Test Plan:
- Reset, then dispatch pc 0x100/0x104 → disp_rob_idx 0/1, rob_count=2. Complete idx1, then idx0 → next cycle ret_valid=0b0011 with pc 0x100 on lane 0, then rob_count=0.
- 32 cycles of 2-lane dispatch → rob_count=64, disp_ready=0. Complete idx 0–3 → ret_valid=0b1111; the cycle after, disp_ready=1.
- Wrap: advance head/tail to 62, dispatch 4 → idx 62,63,0,1. Complete all → retire order 62,63,0,1 across the wrap; tail wrap bit toggled.
- Mispredict: idx 0–3 done, idx1 cmpl_br_mispred=1 → ret_valid=0b0011. Next cycle flush=1, flush_pc=pc of idx1, rob_count=0; idx2/3 never appear on ret_entry.
- Four FUs completing idx 5,6,7,7 in one cycle, with FU3 exception=1 → idx7 done and flagged; retire stops after idx7, then flush.
- rst_n low for one edge with rob_count=20 and a flagged entry at head → next cycle rob_count=0, ret_valid=0, flush=0, disp_ready=1.
